// File: rtl/check_dumper.sv
// Purpose: walks check_addr over [FIRST_ADDR, LAST_ADDR] and streams each captured word as "AA:DDDDDDDD\r\n" ASCII.
// Latency: 1 capture cycle + 13 byte cycles per entry; done pulses at cycle 1+14*N after start with tx_ready held high.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; start is ignored while busy or in DONE.
module check_dumper #(
  parameter logic [7:0] FIRST_ADDR = 8'h01,
  parameter logic [7:0] LAST_ADDR  = 8'h14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [31:0] check_addr,
  input  logic [31:0] check_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Index of the last byte of an entry (LF).
  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t      state_q, state_d;
  logic [7:0]  addr_q,  addr_d;
  logic [31:0] data_q,  data_d;
  logic [3:0]  idx_q,   idx_d;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // State, address, captured word and byte index registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      data_q  <= 32'h0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: capture once per entry, then advance through the 13 bytes on each handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = FIRST_ADDR;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // check_addr has been stable for the whole cycle, so the selector output is settled here.
        data_d  = check_data;
        idx_d   = 4'd0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 4'd1;
          end else if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = CAPTURE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte decode from registered address/data/index only; zero outside SEND.
  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    tx_data = hex_char(addr_q[7:4]);
        4'd1:    tx_data = hex_char(addr_q[3:0]);
        4'd2:    tx_data = 8'h3A;
        4'd3:    tx_data = hex_char(data_q[31:28]);
        4'd4:    tx_data = hex_char(data_q[27:24]);
        4'd5:    tx_data = hex_char(data_q[23:20]);
        4'd6:    tx_data = hex_char(data_q[19:16]);
        4'd7:    tx_data = hex_char(data_q[15:12]);
        4'd8:    tx_data = hex_char(data_q[11:8]);
        4'd9:    tx_data = hex_char(data_q[7:4]);
        4'd10:   tx_data = hex_char(data_q[3:0]);
        4'd11:   tx_data = 8'h0D;
        4'd12:   tx_data = 8'h0A;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign check_addr = {24'h0, addr_q};
  assign tx_valid   = (state_q == SEND);
  assign busy       = (state_q == CAPTURE) || (state_q == SEND);
  assign done       = (state_q == DONE);

endmodule
